// File: rtl/instruction_fetch_buffer.sv
// Instruction fetch buffer: issues single outstanding reads to instruction
// memory and queues {pc, instr} pairs for decode, with redirect flushing.
module instruction_fetch_buffer #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        ifb_clk,
    input  logic        ifb_rst,
    input  logic [31:0] ifb_pc_in,
    output logic        ifb_cnt_out,
    input  logic        ifb_flush,
    output logic        ifb_mem_req,
    output logic [31:0] ifb_mem_addr,
    input  logic        ifb_mem_rvalid,
    input  logic [31:0] ifb_mem_rdata,
    output logic        ifb_valid,
    input  logic        ifb_ready,
    output logic [31:0] ifb_instr,
    output logic [31:0] ifb_pc_out
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [31:0]   req_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   fifo_pc  [FIFO_DEPTH];
    logic [31:0]   fifo_ins [FIFO_DEPTH];

    logic not_full;
    logic issue;
    logic push;
    logic pop;

    // Handshake decode; space is judged on the pre-pop count
    always_comb begin
        not_full     = count < CW'(FIFO_DEPTH);
        issue        = !ifb_rst && (state == IDLE) && !ifb_flush && not_full;
        push         = (state == WAIT) && ifb_mem_rvalid && !ifb_flush;
        ifb_valid    = count != '0;
        pop          = ifb_valid && ifb_ready && !ifb_flush;
        ifb_mem_req  = issue;
        ifb_cnt_out  = issue;
        ifb_mem_addr = issue ? ifb_pc_in : '0;
        ifb_instr    = ifb_valid ? fifo_ins[rd_ptr] : '0;
        ifb_pc_out   = ifb_valid ? fifo_pc[rd_ptr] : '0;
    end

    // Next-state: track whether a response is owed and whether to keep it
    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            state == IDLE: if (issue) state_nxt = WAIT;
            state == WAIT: begin
                if (ifb_mem_rvalid)
                    state_nxt = IDLE;
                else if (ifb_flush)
                    state_nxt = DROP;
            end
            state == DROP: if (ifb_mem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and captured request PC
    always_ff @(posedge ifb_clk or posedge ifb_rst) begin
        if (ifb_rst) begin
            state  <= IDLE;
            req_pc <= '0;
        end else begin
            state <= state_nxt;
            if (issue)
                req_pc <= ifb_pc_in;
        end
    end

    // FIFO pointers and occupancy; redirect empties the queue
    always_ff @(posedge ifb_clk or posedge ifb_rst) begin
        if (ifb_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (ifb_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage, written at the tail on accepted responses
    always_ff @(posedge ifb_clk) begin
        if (push) begin
            fifo_pc[wr_ptr]  <= req_pc;
            fifo_ins[wr_ptr] <= ifb_mem_rdata;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Bench for instruction_fetch_buffer: directed vector table, reset and
// wrap sequences, and randomized traffic against a queue-based model.
module tb_instruction_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0;
    logic        flush = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        ready = 1'b0;

    logic        req2, cnt2, vld2, req4, cnt4, vld4;
    logic [31:0] addr2, ins2, pco2, addr4, ins4, pco4;

    bit          sel = 1'b0;
    logic        req, cnt, valid;
    logic [31:0] addr, instr, pc_out;

    assign req    = sel ? req4  : req2;
    assign cnt    = sel ? cnt4  : cnt2;
    assign valid  = sel ? vld4  : vld2;
    assign addr   = sel ? addr4 : addr2;
    assign instr  = sel ? ins4  : ins2;
    assign pc_out = sel ? pco4  : pco2;

    always #5 clk = ~clk;

    instruction_fetch_buffer #(.FIFO_DEPTH(2)) dut2 (
        .ifb_clk(clk), .ifb_rst(rst), .ifb_pc_in(pc_in),
        .ifb_cnt_out(cnt2), .ifb_flush(flush), .ifb_mem_req(req2),
        .ifb_mem_addr(addr2), .ifb_mem_rvalid(rvalid),
        .ifb_mem_rdata(rdata), .ifb_valid(vld2), .ifb_ready(ready),
        .ifb_instr(ins2), .ifb_pc_out(pco2)
    );

    instruction_fetch_buffer #(.FIFO_DEPTH(4)) dut4 (
        .ifb_clk(clk), .ifb_rst(rst), .ifb_pc_in(pc_in),
        .ifb_cnt_out(cnt4), .ifb_flush(flush), .ifb_mem_req(req4),
        .ifb_mem_addr(addr4), .ifb_mem_rvalid(rvalid),
        .ifb_mem_rdata(rdata), .ifb_valid(vld4), .ifb_ready(ready),
        .ifb_instr(ins4), .ifb_pc_out(pco4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic r, input logic c,
                           input logic [31:0] ad, input logic v,
                           input logic [31:0] in, input logic [31:0] po);
        chk({tag, ".mem_req"}, req, r);
        chk({tag, ".cnt_out"}, cnt, c);
        chk({tag, ".mem_addr"}, addr, ad);
        chk({tag, ".valid"}, valid, v);
        chk({tag, ".instr"}, instr, in);
        chk({tag, ".pc_out"}, pc_out, po);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] pc;
        logic        fl;
        logic        rv;
        logic [31:0] rd;
        logic        rdy;
        logic        e_req;
        logic        e_cnt;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_ins;
        logic [31:0] e_pco;
    } vec_t;

    function automatic vec_t mk(logic [31:0] p, logic f, logic rv,
                                logic [31:0] rd, logic rdy, logic er,
                                logic ec, logic [31:0] ea, logic ev,
                                logic [31:0] ei, logic [31:0] ep);
        vec_t v;
        v.pc = p; v.fl = f; v.rv = rv; v.rd = rd; v.rdy = rdy;
        v.e_req = er; v.e_cnt = ec; v.e_addr = ea; v.e_vld = ev;
        v.e_ins = ei; v.e_pco = ep;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    bit          m_out;
    bit          m_stale;
    logic [31:0] m_pc;
    int          depth;

    function automatic bit m_issue();
        return !m_out && !flush && (mq.size() < depth);
    endfunction

    task automatic model_check();
        bit iss;
        iss = m_issue();
        chk("m.mem_req", req, iss);
        chk("m.cnt_out", cnt, iss);
        chk("m.mem_addr", addr, iss ? pc_in : 32'h0);
        chk("m.valid", valid, mq.size() != 0);
        chk("m.instr", instr, mq.size() != 0 ? mq[0].ins : 32'h0);
        chk("m.pc_out", pc_out, mq.size() != 0 ? mq[0].pc : 32'h0);
    endtask

    task automatic model_step();
        bit iss;
        bit do_pop;
        iss    = m_issue();
        do_pop = (mq.size() != 0) && ready && !flush;
        if (flush) begin
            mq.delete();
            if (m_out && rvalid) begin
                m_out = 0;
                m_stale = 0;
            end else if (m_out) begin
                m_stale = 1;
            end
        end else begin
            if (do_pop)
                void'(mq.pop_front());
            if (m_out && rvalid) begin
                if (!m_stale)
                    mq.push_back('{m_pc, rdata});
                m_out = 0;
                m_stale = 0;
            end
            if (iss) begin
                m_out = 1;
                m_pc  = pc_in;
            end
        end
    endtask

    // ---------------- environment: counter + memory ----------------
    logic [31:0] pc;
    bit          mpend;
    int          mwait;
    int          flush_pct, ready_pct, lat_max, spur_pct;
    logic [31:0] pops[$];

    task automatic env_reset(input int d);
        @(posedge clk);
        #1;
        rst = 1; flush = 1; rvalid = 0; ready = 0;
        #3;
        rst = 0;
        mq.delete();
        m_out = 0; m_stale = 0; m_pc = '0;
        depth = d; pc = '0; mpend = 0; mwait = 0;
        pops.delete();
    endtask

    task automatic env_cycle();
        @(posedge clk);
        #1;
        rvalid = 0;
        rdata  = $urandom;
        if (mpend) begin
            mwait--;
            if (mwait == 0) begin
                rvalid = 1;
                mpend  = 0;
            end
        end else if ($urandom_range(99) < spur_pct) begin
            rvalid = 1;
        end
        flush = ($urandom_range(99) < flush_pct);
        ready = ($urandom_range(99) < ready_pct);
        pc_in = pc;
        #3;
        model_check();
        if (valid && ready && !flush)
            pops.push_back(pc_out);
        if (req) begin
            mpend = 1;
            mwait = $urandom_range(lat_max, 1);
        end
        model_step();
        if (flush)
            pc = $urandom & 32'h0000_FFFC;
        else if (cnt)
            pc = pc + 4;
    endtask

    vec_t tbl[17];

    initial begin
        tbl[0]  = mk(32'h000, 0, 0, 32'h0,        0, 1, 1, 32'h000, 0, 32'h0,        32'h0);
        tbl[1]  = mk(32'h004, 0, 1, 32'h00500093, 0, 0, 0, 32'h000, 0, 32'h0,        32'h0);
        tbl[2]  = mk(32'h004, 0, 0, 32'h0,        0, 1, 1, 32'h004, 1, 32'h00500093, 32'h0);
        tbl[3]  = mk(32'h008, 0, 1, 32'h00400113, 0, 0, 0, 32'h000, 1, 32'h00500093, 32'h0);
        tbl[4]  = mk(32'h008, 0, 0, 32'h0,        0, 0, 0, 32'h000, 1, 32'h00500093, 32'h0);
        tbl[5]  = mk(32'h008, 0, 0, 32'h0,        1, 0, 0, 32'h000, 1, 32'h00500093, 32'h0);
        tbl[6]  = mk(32'h008, 0, 0, 32'h0,        1, 1, 1, 32'h008, 1, 32'h00400113, 32'h4);
        tbl[7]  = mk(32'h100, 1, 0, 32'h0,        1, 0, 0, 32'h000, 0, 32'h0,        32'h0);
        tbl[8]  = mk(32'h100, 0, 1, 32'hDEADBEEF, 1, 0, 0, 32'h000, 0, 32'h0,        32'h0);
        tbl[9]  = mk(32'h100, 0, 0, 32'h0,        1, 1, 1, 32'h100, 0, 32'h0,        32'h0);
        tbl[10] = mk(32'h200, 1, 1, 32'h11111111, 1, 0, 0, 32'h000, 0, 32'h0,        32'h0);
        tbl[11] = mk(32'h200, 0, 0, 32'h0,        1, 1, 1, 32'h200, 0, 32'h0,        32'h0);
        tbl[12] = mk(32'h204, 0, 1, 32'h22222222, 0, 0, 0, 32'h000, 0, 32'h0,        32'h0);
        tbl[13] = mk(32'h204, 0, 0, 32'h0,        0, 1, 1, 32'h204, 1, 32'h22222222, 32'h200);
        tbl[14] = mk(32'h208, 0, 1, 32'h33333333, 1, 0, 0, 32'h000, 1, 32'h22222222, 32'h200);
        tbl[15] = mk(32'h208, 0, 1, 32'h0BAD0BAD, 0, 1, 1, 32'h208, 1, 32'h33333333, 32'h204);
        tbl[16] = mk(32'h20C, 0, 0, 32'h0,        0, 0, 0, 32'h000, 1, 32'h33333333, 32'h204);

        // Outputs held at zero while reset is asserted
        sel = 0;
        @(posedge clk);
        #1;
        pc_in = 32'h1234; flush = 0; rvalid = 1; rdata = 32'hFFFF_FFFF;
        ready = 1;
        #3;
        chk_all("in_reset", 0, 0, 32'h0, 0, 32'h0, 32'h0);

        // Directed table: first row is the first cycle out of reset
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            rst = 0;
            pc_in = tbl[i].pc; flush = tbl[i].fl; rvalid = tbl[i].rv;
            rdata = tbl[i].rd; ready = tbl[i].rdy;
            #3;
            chk_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_cnt,
                    tbl[i].e_addr, tbl[i].e_vld, tbl[i].e_ins,
                    tbl[i].e_pco);
        end

        // Asynchronous reset mid-request; late response must be ignored
        @(posedge clk);
        #1;
        rvalid = 0; flush = 0; ready = 0; pc_in = 32'h210;
        #2;
        rst = 1;
        #2;
        chk_all("async_rst", 0, 0, 32'h0, 0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst = 0; pc_in = 32'h40; rvalid = 1; rdata = 32'hBAD0BAD0;
        #3;
        chk_all("rst_rel", 1, 1, 32'h40, 0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rvalid = 0; pc_in = 32'h44;
        #3;
        chk_all("rst_w1", 0, 0, 32'h0, 0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rvalid = 1; rdata = 32'h00000013;
        #3;
        chk_all("rst_w2", 0, 0, 32'h0, 0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rvalid = 0;
        #3;
        chk_all("rst_w3", 1, 1, 32'h44, 1, 32'h13, 32'h40);

        // Depth-4 continuous stream over ten instructions (pointer wrap)
        sel = 1;
        env_reset(4);
        flush_pct = 0; ready_pct = 100; lat_max = 1; spur_pct = 0;
        for (int c = 0; c < 200 && pops.size() < 10; c++)
            env_cycle();
        chk("wrap.pops", pops.size() >= 10, 1);
        for (int i = 0; i < 10 && i < pops.size(); i++)
            chk($sformatf("wrap.pc%0d", i), pops[i], 32'(i * 4));

        // Randomized traffic, both depths
        for (int s = 1; s >= 0; s--) begin
            sel = (s == 1);
            env_reset(s == 1 ? 4 : 2);
            flush_pct = 5; ready_pct = 60; lat_max = 3; spur_pct = 10;
            for (int c = 0; c < 600; c++)
                env_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
